// File: rtl/taxi_baser_tx_gbx_pkg.sv
// Shared constants for the BASE-R transmit gearbox: block timing, sync headers
// and the PRBS31 polynomial taps.
package taxi_baser_pkg;

  localparam int GBX_SEQ_LEN = 33;
  localparam int BLOCK_W     = 66;

  typedef enum logic [1:0] {
    SYNC_DATA = 2'b01,
    SYNC_CTRL = 2'b10
  } sync_hdr_t;

  // x^31 + x^28 + 1: new bit = s[30] ^ s[27], shifted in at bit 0.
  localparam int PRBS31_W     = 31;
  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;

endpackage

// File: rtl/taxi_baser_tx_gbx_if.sv
// Encoder-to-gearbox bus: one 64b/66b block (or half block in 32-bit mode) per
// cycle, paced by the gearbox.
interface taxi_baser_tx_gbx_if #(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 2
) ();

  // Handshake: the gearbox owns the pace. When tx_gbx_req_stall is high the
  // encoder holds and drives data_valid=0; on every other cycle it must drive
  // data_valid=1, and hdr_valid must equal tx_gbx_req_sync (block start).
  logic [DATA_W-1:0] encoded_tx_data;
  logic              encoded_tx_data_valid;
  logic [HDR_W-1:0]  encoded_tx_hdr;
  logic              encoded_tx_hdr_valid;
  logic              tx_gbx_req_sync;
  logic              tx_gbx_req_stall;

  modport master (
    output encoded_tx_data, encoded_tx_data_valid,
    output encoded_tx_hdr, encoded_tx_hdr_valid,
    input  tx_gbx_req_sync, tx_gbx_req_stall
  );

  modport slave (
    input  encoded_tx_data, encoded_tx_data_valid,
    input  encoded_tx_hdr, encoded_tx_hdr_valid,
    output tx_gbx_req_sync, tx_gbx_req_stall
  );

endinterface

// File: rtl/taxi_baser_tx_gbx_prbs.sv
// PRBS31 generator producing DATA_W bits per cycle; data_o[0] is the oldest
// bit of the word. Seeded all-ones on reset.
module taxi_prbs31_gen
  import taxi_baser_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output logic [DATA_W-1:0] data_o
);

  logic [PRBS31_W-1:0] state_q, state_d;
  logic                fb;

  always_comb begin
    state_d = state_q;
    data_o  = '0;
    fb      = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb        = state_d[PRBS31_TAP_A] ^ state_d[PRBS31_TAP_B];
      data_o[i] = fb;
      state_d   = {state_d[PRBS31_W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '1;
    end else if (enable_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/taxi_baser_tx_gbx.sv
// 66:DATA_W transmit gearbox: packs header+payload into a continuous SERDES
// word stream on a fixed 33-cycle schedule, with optional PRBS31 override.
module taxi_baser_tx_gbx
  import taxi_baser_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int HDR_W       = 2,
  parameter bit BIT_REVERSE = 1'b0,
  parameter bit PRBS31_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  taxi_baser_tx_gbx_if.slave  enc_if,
  input  logic                cfg_tx_prbs31_enable,
  output logic [DATA_W-1:0]   serdes_tx_data,
  output logic                stat_tx_gbx_err
);

  localparam int BUF_W = 2*DATA_W + HDR_W;
  localparam int SEQ_W = $clog2(GBX_SEQ_LEN);
  localparam int OCC_W = $clog2(BUF_W + 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(GBX_SEQ_LEN - 1);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              err_q, err_d;

  logic              sched_sync, sched_stall;
  logic [BUF_W-1:0]  ins_ext, cat;
  logic [OCC_W-1:0]  n_in;
  logic [DATA_W-1:0] gbx_word, prbs_word, sel_word;

  // 64-bit mode takes a block every non-stall cycle; 32-bit mode on even seq.
  assign sched_stall = (seq_q == SEQ_LAST);
  assign sched_sync  = !sched_stall && ((DATA_W == 64) || !seq_q[0]);

  assign enc_if.tx_gbx_req_sync  = rst_n & sched_sync;
  assign enc_if.tx_gbx_req_stall = sched_stall;

  if (PRBS31_EN) begin : g_prbs
    taxi_prbs31_gen #(.DATA_W(DATA_W)) u_prbs (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (1'b1),
      .data_o   (prbs_word)
    );
  end else begin : g_no_prbs
    assign prbs_word = '0;
  end

  always_comb begin
    seq_d   = sched_stall ? '0 : seq_q + 1'b1;
    ins_ext = '0;
    n_in    = '0;
    if (sched_sync) begin
      ins_ext = BUF_W'({enc_if.encoded_tx_data, enc_if.encoded_tx_hdr});
      n_in    = OCC_W'(DATA_W + HDR_W);
    end else if (!sched_stall) begin
      ins_ext = BUF_W'(enc_if.encoded_tx_data);
      n_in    = OCC_W'(DATA_W);
    end
    // Residual bits sit at the bottom; bits above occ_q are always zero.
    cat      = buf_q | (ins_ext << occ_q);
    gbx_word = cat[DATA_W-1:0];
    buf_d    = cat >> DATA_W;
    occ_d    = occ_q + n_in - OCC_W'(DATA_W);

    err_d = sched_stall ? enc_if.encoded_tx_data_valid
                        : (!enc_if.encoded_tx_data_valid ||
                           (enc_if.encoded_tx_hdr_valid != sched_sync));

    sel_word = (PRBS31_EN && cfg_tx_prbs31_enable) ? prbs_word : gbx_word;
    out_d    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      out_d[i] = BIT_REVERSE ? sel_word[DATA_W-1-i] : sel_word[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
      occ_q <= '0;
      buf_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      occ_q <= occ_d;
      buf_q <= buf_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign serdes_tx_data  = out_q;
  assign stat_tx_gbx_err = err_q;

  occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    (occ_q <= OCC_W'(2*DATA_W)) &&
    (({1'b0, occ_q} + {1'b0, n_in}) <= (OCC_W+1)'(BUF_W)));

endmodule

// File: tb/tb_taxi_baser_tx_gbx.sv
// Bench for the BASE-R TX gearbox: 64-bit, 32-bit and bit-reversed 64-bit
// instances checked against a serial bit-stream model and a PRBS31 recurrence.
module tb_taxi_baser_tx_gbx;
  import taxi_baser_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_prbs = 1'b0;
  always #5 clk = ~clk;

  taxi_baser_tx_gbx_if #(.DATA_W(64)) if64 ();
  taxi_baser_tx_gbx_if #(.DATA_W(32)) if32 ();
  taxi_baser_tx_gbx_if #(.DATA_W(64)) ifr ();

  assign ifr.encoded_tx_data       = if64.encoded_tx_data;
  assign ifr.encoded_tx_data_valid = if64.encoded_tx_data_valid;
  assign ifr.encoded_tx_hdr        = if64.encoded_tx_hdr;
  assign ifr.encoded_tx_hdr_valid  = if64.encoded_tx_hdr_valid;

  logic [63:0] out64, outr;
  logic [31:0] out32;
  logic        err64, err32, errr;

  taxi_baser_tx_gbx #(.DATA_W(64), .BIT_REVERSE(1'b0), .PRBS31_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .enc_if(if64), .cfg_tx_prbs31_enable(cfg_prbs),
    .serdes_tx_data(out64), .stat_tx_gbx_err(err64));

  taxi_baser_tx_gbx #(.DATA_W(32), .BIT_REVERSE(1'b0), .PRBS31_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .enc_if(if32), .cfg_tx_prbs31_enable(cfg_prbs),
    .serdes_tx_data(out32), .stat_tx_gbx_err(err32));

  taxi_baser_tx_gbx #(.DATA_W(64), .BIT_REVERSE(1'b1), .PRBS31_EN(1'b1)) dutr (
    .clk(clk), .rst_n(rst_n), .enc_if(ifr), .cfg_tx_prbs31_enable(cfg_prbs),
    .serdes_tx_data(outr), .stat_tx_gbx_err(errr));

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int n = 0;
  bit s64[$];
  bit s32[$];
  bit pr[$];
  logic [63:0] exp64_q[$];
  logic [31:0] exp32_q[$];
  logic        experr64_q[$];
  logic        experr32_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %h exp %h", tag, n, got, exp);
    end
  endtask

  // PRBS31 bit i from p[k] = p[k-31] ^ p[k-28], with p[<0] = 1.
  function automatic bit prbs_bit(input int i);
    int j;
    bit a, b;
    while (pr.size() <= i) begin
      j = pr.size();
      a = (j < 31) ? 1'b1 : pr[j-31];
      b = (j < 28) ? 1'b1 : pr[j-28];
      pr.push_back(a ^ b);
    end
    return pr[i];
  endfunction

  // driver + model: inputs for the coming edge, expected words for after it
  task automatic drive_cycle(input bit directed, input bit stall_err);
    int seq;
    bit st, sy64, sy32;
    logic [63:0] d64, e64w;
    logic [31:0] d32, e32w;
    logic [1:0]  h64, h32;
    logic        dv64, hv64, dv32, hv32;
    seq  = n % GBX_SEQ_LEN;
    st   = (seq == GBX_SEQ_LEN - 1);
    sy64 = !st;
    sy32 = !st && (seq % 2 == 0);
    check("req_sync64", 64'(if64.tx_gbx_req_sync), 64'(sy64));
    check("req_stall64", 64'(if64.tx_gbx_req_stall), 64'(st));
    check("req_sync32", 64'(if32.tx_gbx_req_sync), 64'(sy32));
    check("req_stall32", 64'(if32.tx_gbx_req_stall), 64'(st));
    check("req_stall_rev", 64'(ifr.tx_gbx_req_stall), 64'(st));

    d64  = {$urandom(), $urandom()};
    d32  = $urandom();
    h64  = 2'($urandom_range(0, 3));
    h32  = 2'($urandom_range(0, 3));
    dv64 = !st; hv64 = sy64;
    dv32 = !st; hv32 = sy32;
    if (directed) begin
      h64 = SYNC_CTRL;
      d64 = 64'h1E;
    end else begin
      if (stall_err && st) dv64 = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) dv64 = !dv64; else hv64 = !hv64;
      end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) dv32 = !dv32; else hv32 = !hv32;
      end
    end
    if64.encoded_tx_data       = d64;
    if64.encoded_tx_hdr        = h64;
    if64.encoded_tx_data_valid = dv64;
    if64.encoded_tx_hdr_valid  = hv64;
    if32.encoded_tx_data       = d32;
    if32.encoded_tx_hdr        = h32;
    if32.encoded_tx_data_valid = dv32;
    if32.encoded_tx_hdr_valid  = hv32;

    // The wire is one serial stream: header bits then payload, bit 0 first.
    if (sy64) begin s64.push_back(h64[0]); s64.push_back(h64[1]); end
    if (!st) for (int i = 0; i < 64; i++) s64.push_back(d64[i]);
    for (int i = 0; i < 64; i++) e64w[i] = s64.pop_front();
    if (cfg_prbs) for (int i = 0; i < 64; i++) e64w[i] = prbs_bit(n*64 + i);
    exp64_q.push_back(e64w);
    experr64_q.push_back(st ? dv64 : (!dv64 || (hv64 != sy64)));

    if (sy32) begin s32.push_back(h32[0]); s32.push_back(h32[1]); end
    if (!st) for (int i = 0; i < 32; i++) s32.push_back(d32[i]);
    for (int i = 0; i < 32; i++) e32w[i] = s32.pop_front();
    if (cfg_prbs) for (int i = 0; i < 32; i++) e32w[i] = prbs_bit(n*32 + i);
    exp32_q.push_back(e32w);
    experr32_q.push_back(st ? dv32 : (!dv32 || (hv32 != sy32)));
  endtask

  task automatic check_outputs();
    logic [63:0] e64, er;
    logic [31:0] e32;
    logic        ee64, ee32;
    e64  = exp64_q.pop_front();
    e32  = exp32_q.pop_front();
    ee64 = experr64_q.pop_front();
    ee32 = experr32_q.pop_front();
    for (int i = 0; i < 64; i++) er[i] = e64[63-i];
    check("serdes64", out64, e64);
    check("serdes_rev", outr, er);
    check("serdes32", 64'(out32), 64'(e32));
    check("err64", 64'(err64), 64'(ee64));
    check("err_rev", 64'(errr), 64'(ee64));
    check("err32", 64'(err32), 64'(ee32));
  endtask

  task automatic run_cycles(input int cnt, input bit stall_err, input bit directed_first);
    for (int c = 0; c < cnt; c++) begin
      drive_cycle(directed_first && (c == 0), stall_err && (((n / GBX_SEQ_LEN) % 4) == 1));
      @(posedge clk);
      n++;
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out64"}, out64, 64'h0);
    check({tag, "_out32"}, 64'(out32), 64'h0);
    check({tag, "_outr"}, outr, 64'h0);
    check({tag, "_err"}, 64'({err64, err32, errr}), 64'h0);
    check({tag, "_sync"}, 64'({if64.tx_gbx_req_sync, if32.tx_gbx_req_sync, ifr.tx_gbx_req_sync}), 64'h0);
    check({tag, "_stall"}, 64'({if64.tx_gbx_req_stall, if32.tx_gbx_req_stall, ifr.tx_gbx_req_stall}), 64'h0);
  endtask

  initial begin
    if64.encoded_tx_data = '0; if64.encoded_tx_hdr = '0;
    if64.encoded_tx_data_valid = 1'b0; if64.encoded_tx_hdr_valid = 1'b0;
    if32.encoded_tx_data = '0; if32.encoded_tx_hdr = '0;
    if32.encoded_tx_data_valid = 1'b0; if32.encoded_tx_hdr_valid = 1'b0;
    cfg_prbs = 1'b1;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // PRBS from reset, gearbox still consuming underneath
    run_cycles(10000, 1'b0, 1'b0);
    cfg_prbs = 1'b0;
    run_cycles(1000, 1'b1, 1'b0);
    cfg_prbs = 1'b1;
    run_cycles(100, 1'b0, 1'b0);
    cfg_prbs = 1'b0;
    run_cycles(300, 1'b1, 1'b0);

    // asynchronous reset in the middle of a period
    while ((n % GBX_SEQ_LEN) != 17) run_cycles(1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    s64.delete(); s32.delete();
    exp64_q.delete(); exp32_q.delete();
    experr64_q.delete(); experr32_q.delete();
    n = 0;
    rst_n = 1'b1;
    #1;
    run_cycles(200, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/taxi_baser_tx_gbx.md
Name: taxi_baser_tx_gbx

Overview:
- Transmit 66:DATA_W gearbox for 10GBASE-R/25GBASE-R PHY datapaths.
- Sits between the 64b/66b encoder and SERDES TX. Packs 2-bit sync header plus payload into a continuous DATA_W-bit SERDES stream.
- Generates the tx_gbx_req_sync and tx_gbx_req_stall pacing that upstream encoders consume.
- Adds a 32-bit datapath mode, optional SERDES bit reversal, and a PRBS31 transmit test pattern.

Parameters:
- DATA_W, 64, SERDES/encoder word width; legal values 32 or 64.
- HDR_W, 2, sync header width; fixed at 2.
- BIT_REVERSE, 1'b0, reverse bit order of serdes_tx_data.
- PRBS31_EN, 1'b1, include PRBS31 generator; when 0, cfg_tx_prbs31_enable is ignored.

Ports:
- clk  in  1  datapath clock
- rst_n  in  1  asynchronous active-low reset
- encoded_tx_data  in  DATA_W  encoder payload, bit 0 first on the wire
- encoded_tx_data_valid  in  1  payload valid
- encoded_tx_hdr  in  HDR_W  sync header (2'b01 data, 2'b10 control)
- encoded_tx_hdr_valid  in  1  header valid; marks block start
- tx_gbx_req_sync  out  1  upstream must present a block start this cycle
- tx_gbx_req_stall  out  1  upstream must hold this cycle; no data consumed
- serdes_tx_data  out  DATA_W  gearboxed SERDES word
- cfg_tx_prbs31_enable  in  1  replace output with PRBS31
- stat_tx_gbx_err  out  1  single-cycle pulse on an upstream protocol violation

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n. Reset is asynchronous, active low, and clears immediately, including mid-sequence.
  - Outputs after reset: serdes_tx_data=0, req_sync=0, req_stall=0, stat_tx_gbx_err=0.
  - Internal state after reset: seq=0, occupancy=0, PRBS state all-ones.
  - After deassertion, seq starts at 0 on the first clock.
- Sequence counter: seq runs 0..32 and wraps (period 33, package constant GBX_SEQ_LEN).
  - tx_gbx_req_stall = (seq==32), driven combinationally from the registered seq.
  - DATA_W=64: req_sync=1 on every non-stall cycle.
  - DATA_W=32: req_sync=1 on even seq 0..30, giving 16 blocks per period.
- Consumption follows the schedule, not the valid signals.
  - On a req_sync cycle, append hdr then data (+DATA_W+2 bits).
  - On a non-sync, non-stall cycle (32-bit mode), append data (+DATA_W).
  - On a stall cycle, append nothing.
  - Every cycle, shift out DATA_W bits.
- Occupancy:
  - DATA_W=64: occupancy grows by 2 per cycle and reaches 64 at seq 32; the stall cycle drains it to 0.
  - DATA_W=32: occupancy grows by 2 per block and reaches 32 at seq 32; the stall cycle drains it to 0.
  - Buffer is 2*DATA_W+2 bits. Occupancy never exceeds 2*DATA_W; any overflow is a design error and must fire an assertion.
- Bit order: hdr[0] is transmitted first, then hdr[1], then data[0..]. serdes_tx_data[0] is the first bit out. BIT_REVERSE mirrors the whole output word.
- Latency: one cycle (registered output). Input bit at buffer position p appears at serdes_tx_data[p] on the next cycle.
- Errors:
  - stat_tx_gbx_err pulses the cycle after any of:
    - data_valid=1 during a stall;
    - data_valid=0 on a non-stall cycle;
    - hdr_valid!=req_sync on a non-stall cycle.
  - Errors do not alter the schedule; the input bits are still consumed as scheduled.
- PRBS31 (x^31+x^28+1):
  - Advances DATA_W bits every cycle, including stall cycles.
  - When cfg_tx_prbs31_enable=1, serdes_tx_data = PRBS word (BIT_REVERSE still applies).
  - The gearbox schedule and buffer keep running, so deassertion resumes aligned output.
  - The enable change takes effect on the next output word.

Decomposition:
- Package taxi_baser_pkg:
  - GBX_SEQ_LEN=33
  - BLOCK_W=66
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - PRBS31 tap constants
- Sub-module taxi_prbs31_gen: parameter DATA_W; clk/rst_n; enable; DATA_W output; seed all-ones; unrolled next-state.

Test Plan:
- Reset release, DATA_W=64, hdr=2'b10, data=64'h1E → req_stall high at cycles 32, 65, 98. Output bits [1:0] of the first word = 2'b10, bits [63:2] = data[61:0]. The stall-cycle word equals the 64 residual bits.
- DATA_W=32, 48 blocks of counter payload → req_sync on seq 0,2,...,30. A descrambled reassembly of the output at 66-bit boundaries matches the input blocks exactly with zero bit slips.
- Drive data_valid=1 at seq 32 → stat_tx_gbx_err=1 for exactly one cycle at seq 0 of the next period; the following block is still output correctly aligned.
- cfg_tx_prbs31_enable=1 from reset, BIT_REVERSE=0 → first output word equals the PRBS31 sequence from the all-ones seed. A reference PRBS31 checker reports 0 errors over 10,000 cycles, including stall cycles.
- Toggle PRBS on for 100 cycles then off → the gearbox stream resumes with correct header alignment on the first word after deassertion.
- Assert rst_n=0 at seq 17 → all outputs are 0 in the same cycle (asynchronously). After release, req_stall first rises 33 cycles later and occupancy restarts at 0.
